// File: rtl/regfile_scoreboard.sv
// 8 x 16-bit register file with a per-register busy scoreboard for issue/write-back hazard tracking.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int NREGS  = 8,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_b,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ack,
    output logic [NREGS-1:0]  busy_vec
);

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } busy_state_t;

    logic [DATA_W-1:0] regs [NREGS];
    busy_state_t       state_q [NREGS];
    busy_state_t       state_d [NREGS];
    logic              wr_ok;
    logic              iss_set;

    assign wr_ok   = wr_en && (wr_addr != '0);
    assign iss_ack = iss_en && ((iss_addr == '0) || !busy_vec[iss_addr] ||
                                (wr_en && (wr_addr == iss_addr)));
    assign iss_set = iss_ack && (iss_addr != '0);

    // Per-register busy FSM: write-back frees, an accepted issue reserves and wins over a same-address write.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            state_d[i] = state_q[i];
            if (wr_ok && (wr_addr == ADDR_W'(i)))
                state_d[i] = FREE;
            if (iss_set && (iss_addr == ADDR_W'(i)))
                state_d[i] = BUSY;
        end
        state_d[0] = FREE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                state_q[i] <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // R0 is never written, so it keeps its reset value of zero forever.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < NREGS; i++)
            busy_vec[i] = (state_q[i] == BUSY);
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // A forwarded read sees the write-back as done unless a same-cycle issue re-reserves the register.
    assign fwd_a     = wr_ok && (rd_addr_a == wr_addr);
    assign fwd_b     = wr_ok && (rd_addr_b == wr_addr);
    assign rd_data_a = fwd_a ? wr_data : regs[rd_addr_a];
    assign rd_data_b = fwd_b ? wr_data : regs[rd_addr_b];
    assign rd_busy_a = fwd_a ? (iss_set && (iss_addr == rd_addr_a)) : busy_vec[rd_addr_a];
    assign rd_busy_b = fwd_b ? (iss_set && (iss_addr == rd_addr_b)) : busy_vec[rd_addr_b];
`else
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign rd_busy_a = busy_vec[rd_addr_a];
    assign rd_busy_b = busy_vec[rd_addr_b];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expectations for same-cycle reads follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic        rd_busy_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic        rd_busy_b;
    logic        iss_en;
    logic [2:0]  iss_addr;
    logic        iss_ack;
    logic [7:0]  busy_vec;

    int checks   = 0;
    int failures = 0;

    regfile_scoreboard #(.NREGS(8), .DATA_W(16), .ADDR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_busy_a (rd_busy_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_busy_b (rd_busy_b),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_ack   (iss_ack),
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, so combinational checks settle well before the next edge.
    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                 input logic ie, input logic [2:0] ia,
                                 input logic [2:0] ra, input logic [2:0] rb);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        iss_en    = ie;
        iss_addr  = ia;
        rd_addr_a = ra;
        rd_addr_b = rb;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
        step();
        reset = 1'b0;

        // Load R3, then reset for two cycles
        applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd0);
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd0);
        checkOutput("r3_loaded", 32'(rd_data_a), 'hBEEF);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checkOutput("rst_r3_data", 32'(rd_data_a), 'h0);
        checkOutput("rst_busy_vec", 32'(busy_vec), 'h00);
        checkOutput("rst_busy_a", 32'(rd_busy_a), 'h0);

        // Plain write, then write attempt to R0
        applyStimulus(1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 3'd0, 3'd2);
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd2);
        checkOutput("r2_data", 32'(rd_data_b), 'h1234);
        checkOutput("r2_busy", 32'(rd_busy_b), 'h0);
        applyStimulus(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd2);
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd2);
        checkOutput("r0_data", 32'(rd_data_a), 'h0);
        checkOutput("r0_busy_vec", 32'(busy_vec), 'h00);

        // Issue R5, WAW refusal, write-back release
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd2);
        checkOutput("iss5_ack", 32'(iss_ack), 'h1);
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd2);
        checkOutput("iss5_busy_vec", 32'(busy_vec), 'h20);
        checkOutput("iss5_busy_a", 32'(rd_busy_a), 'h1);
        checkOutput("idle_ack", 32'(iss_ack), 'h0);
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd2);
        checkOutput("waw5_ack", 32'(iss_ack), 'h0);
        step();
        checkOutput("waw5_busy_vec", 32'(busy_vec), 'h20);
        applyStimulus(1'b1, 3'd5, 16'h00A5, 1'b0, 3'd0, 3'd5, 3'd2);
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd2);
        checkOutput("wb5_busy_vec", 32'(busy_vec), 'h00);
        checkOutput("wb5_data", 32'(rd_data_a), 'h00A5);

        // Issue to R0 is accepted without reserving anything
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 3'd2);
        checkOutput("iss0_ack", 32'(iss_ack), 'h1);
        step();
        checkOutput("iss0_busy_vec", 32'(busy_vec), 'h00);

        // R4 busy, same-cycle write-back and re-issue of R4
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd2);
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd2);
        checkOutput("iss4_busy_vec", 32'(busy_vec), 'h10);
        applyStimulus(1'b1, 3'd4, 16'h0044, 1'b1, 3'd4, 3'd4, 3'd2);
        checkOutput("wbiss4_ack", 32'(iss_ack), 'h1);
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd2);
        checkOutput("wbiss4_data", 32'(rd_data_a), 'h0044);
        checkOutput("wbiss4_busy_vec", 32'(busy_vec), 'h10);
        checkOutput("wbiss4_busy_a", 32'(rd_busy_a), 'h1);
        applyStimulus(1'b1, 3'd4, 16'h0044, 1'b0, 3'd0, 3'd4, 3'd2);
        step();
        checkOutput("wb4_busy_vec", 32'(busy_vec), 'h00);

        // R6 busy, read during its own write-back
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd6, 3'd2);
        step();
        applyStimulus(1'b1, 3'd6, 16'hCAFE, 1'b0, 3'd0, 3'd6, 3'd2);
`ifdef REGFILE_BYPASS_EN
        checkOutput("fwd6_data", 32'(rd_data_a), 'hCAFE);
        checkOutput("fwd6_busy", 32'(rd_busy_a), 'h0);
`else
        checkOutput("old6_data", 32'(rd_data_a), 'h0);
        checkOutput("old6_busy", 32'(rd_busy_a), 'h1);
`endif
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd2);
        checkOutput("wb6_data", 32'(rd_data_a), 'hCAFE);
        checkOutput("wb6_busy", 32'(rd_busy_a), 'h0);

        // Independent write and issue to different registers
        applyStimulus(1'b1, 3'd2, 16'h5555, 1'b1, 3'd3, 3'd3, 3'd2);
        checkOutput("diff_ack", 32'(iss_ack), 'h1);
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd2);
        checkOutput("diff_busy_vec", 32'(busy_vec), 'h08);
        checkOutput("diff_r2_data", 32'(rd_data_b), 'h5555);
        checkOutput("diff_busy_a", 32'(rd_busy_a), 'h1);

        // Reserve R1 and R7, then reset colliding with a write-back of R1
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd1, 3'd2);
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd1, 3'd2);
        step();
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd1, 3'd2);
        checkOutput("pre_rst_busy_vec", 32'(busy_vec), 'h8A);
        applyStimulus(1'b1, 3'd1, 16'h0001, 1'b1, 3'd6, 3'd1, 3'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd1, 3'd2);
        checkOutput("midrst_busy_vec", 32'(busy_vec), 'h00);
        checkOutput("midrst_r1_data", 32'(rd_data_a), 'h0);
        checkOutput("midrst_r2_data", 32'(rd_data_b), 'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 8 x 16-bit general-purpose register file for the 16-bit processor, with a per-register busy scoreboard.
- Sits directly upstream of the datapath registers and ALU operand latches: supplies two operand values plus hazard flags.
- Accepts write-back from the execute stage.
- Issue port reserves a destination register; write-back stores the result and releases the reservation.

Parameters:
NREGS, 8, number of registers (power of two)
DATA_W, 16, register width in bits
ADDR_W, 3, register address width, log2(NREGS)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
wr_en  input  1  write-back strobe
wr_addr  input  ADDR_W  write-back destination
wr_data  input  DATA_W  write-back value
rd_addr_a  input  ADDR_W  operand A address
rd_data_a  output  DATA_W  operand A value (combinational)
rd_busy_a  output  1  operand A has pending write (combinational)
rd_addr_b  input  ADDR_W  operand B address
rd_data_b  output  DATA_W  operand B value (combinational)
rd_busy_b  output  1  operand B has pending write (combinational)
iss_en  input  1  issue request: reserve iss_addr as destination
iss_addr  input  ADDR_W  destination to reserve
iss_ack  output  1  issue accepted this cycle (combinational)
busy_vec  output  NREGS  registered scoreboard, bit i = register i busy

Behaviour:
- Reset: synchronous, checked on rising clk edge, priority over every other input. All registers <= 0, busy_vec <= 0. Combinational outputs then follow: rd_data_* = 0, rd_busy_* = 0.
- Reset asserted mid-operation discards pending reservations and any same-cycle write or issue.
- R0: reads always 0, writes ignored, never marked busy. iss_en to R0 gives iss_ack=1 with no state change.
- Read: rd_data_x = regs[rd_addr_x]; rd_busy_x = busy_vec[rd_addr_x]. Zero-cycle latency, no clock involvement.
- Write: wr_en=1 and wr_addr!=0 stores wr_data into regs[wr_addr] at the edge.
  - Clears busy_vec[wr_addr] unless the same-cycle issue rule below applies.
  - Writing a non-busy register is legal (initial loads); it just stores the value.
- Issue: iss_ack = iss_en & (iss_addr==0 | ~busy_vec[iss_addr] | (wr_en & wr_addr==iss_addr)).
  - If iss_ack=1 and iss_addr!=0, busy_vec[iss_addr] <= 1 at the edge.
  - If iss_ack=0 (WAW hazard), there is no state change; the requester holds iss_en/iss_addr and retries.
- Same-cycle write and issue:
  - Same address: the write stores the data, and the new reservation wins. Busy stays 1 and iss_ack=1.
  - Different addresses: both take effect independently.
- Reading the address being written in the same cycle returns the old value and old busy flag; see Optional Feature.
- Each busy bit is effectively a 2-state FSM per register:
  - FREE -> BUSY on accepted issue.
  - BUSY -> FREE on write-back without a same-address issue.
  - BUSY -> BUSY on write-back with a same-address issue.
  - Any state -> FREE on reset.
- Address wrap: addresses are exactly ADDR_W bits; there are no out-of-range values.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When wr_en=1, wr_addr!=0 and rd_addr_x==wr_addr:
  - rd_data_x = wr_data, and rd_busy_x = 0 in that cycle.
  - Exception: an accepted same-cycle issue to that address keeps rd_busy_x = 1.
- Undefined: no forwarding; the read returns stored contents and the current busy_vec bit. The new value is visible from the next cycle.

Test Plan:
1. reset=1 for 2 cycles after writing R3=16'hBEEF -> rd_data_a(R3)=0, busy_vec=8'h00.
2. wr_en, wr_addr=2, wr_data=16'h1234, no issue -> next cycle rd_data_b(R2)=16'h1234, rd_busy_b=0; write to R0 with 16'hFFFF -> R0 reads 0.
3. iss_en, iss_addr=5 -> iss_ack=1, next cycle busy_vec=8'h20, rd_busy_a(R5)=1. Second iss_en to R5 -> iss_ack=0, busy_vec unchanged. Write-back R5=16'h00A5 -> busy_vec=8'h00, R5 reads 16'h00A5.
4. R4 busy; same-cycle wr_en(R4, 16'h0044) and iss_en(R4) -> iss_ack=1, R4=16'h0044, busy_vec[4] stays 1.
5. Same cycle: wr_en(R6, 16'hCAFE), rd_addr_a=6, R6 busy.
   - With REGFILE_BYPASS_EN: rd_data_a=16'hCAFE, rd_busy_a=0.
   - Without it: old value returned, rd_busy_a=1.
   - Next cycle, both builds: rd_data_a=16'hCAFE, rd_busy_a=0.
6. Issue R1 and R7, then assert reset in the same cycle as wr_en(R1, 16'h0001) -> busy_vec=0, R1=0.
